// File: rtl/map_ram_ctrl.sv
// Tile-map RAM controller: cell write/read, full-map fill and row collapse over a 1R/1W RAM.
// Optional macro MAPCTRL_BOUNDS_CHECK_EN rejects out-of-range coordinates with a cmd_err pulse.
module map_ram_ctrl #(
    parameter int COLS = 40,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_x,
    input  logic [4:0]  cmd_y,
    input  logic [3:0]  cmd_data,
    output logic        rsp_valid,
    output logic [3:0]  rsp_data,
    output logic        busy,
    output logic        cmd_err,
    output logic        ram_wen,
    output logic [11:0] ram_waddr,
    output logic [3:0]  ram_wdata,
    output logic        ram_ren,
    output logic [11:0] ram_raddr,
    input  logic [3:0]  ram_rdata
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR       = 3'd1;
    localparam logic [2:0] RD_ISSUE = 3'd2;
    localparam logic [2:0] RD_DATA  = 3'd3;
    localparam logic [2:0] CLR      = 3'd4;
    localparam logic [2:0] CP_RD    = 3'd5;
    localparam logic [2:0] CP_WR    = 3'd6;
    localparam logic [2:0] CP_TOP   = 3'd7;

    localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);
    localparam logic [5:0]  LAST_X    = 6'(COLS - 1);
    localparam logic [11:0] COLS_W    = 12'(COLS);

    logic [2:0]  state;
    logic [5:0]  x_cnt;
    logic [4:0]  y_cnt;
    logic [11:0] clr_cnt;
    logic [3:0]  data_q;
    logic        reject;
    logic [11:0] cell_addr;
    logic [11:0] src_addr;

`ifdef MAPCTRL_BOUNDS_CHECK_EN
    always_comb begin
        reject = 1'b0;
        if (cmd_op != 2'd2 && int'(cmd_y) >= ROWS)
            reject = 1'b1;
        if (cmd_op[1] == 1'b0 && int'(cmd_x) >= COLS)
            reject = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cmd_err <= 1'b0;
        else
            cmd_err <= cmd_valid && (state == IDLE) && reject;
    end
`else
    assign reject  = 1'b0;
    assign cmd_err = 1'b0;
`endif

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Constant-coefficient multiply; collapse reads from the row above the one being written.
    assign cell_addr = 12'(y_cnt) * COLS_W + 12'(x_cnt);
    assign src_addr  = 12'(5'(y_cnt - 5'd1)) * COLS_W + 12'(x_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x_cnt     <= '0;
            y_cnt     <= '0;
            clr_cnt   <= '0;
            data_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && !reject) begin
                        x_cnt   <= (cmd_op == 2'd3) ? 6'd0 : cmd_x;
                        y_cnt   <= cmd_y;
                        data_q  <= cmd_data;
                        clr_cnt <= '0;
                        case (cmd_op)
                            2'd0:    state <= WR;
                            2'd1:    state <= RD_ISSUE;
                            2'd2:    state <= CLR;
                            default: state <= (cmd_y == 5'd0) ? CP_TOP : CP_RD;
                        endcase
                    end
                end
                WR:       state <= IDLE;
                RD_ISSUE: state <= RD_DATA;
                RD_DATA: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= ram_rdata;
                    state     <= IDLE;
                end
                CLR: begin
                    if (clr_cnt == LAST_CELL)
                        state <= IDLE;
                    else
                        clr_cnt <= clr_cnt + 12'd1;
                end
                CP_RD:    state <= CP_WR;
                CP_WR: begin
                    state <= CP_RD;
                    if (x_cnt == LAST_X) begin
                        x_cnt <= '0;
                        // Row 1 is the last destination row; row 0 is then zero-filled.
                        if (y_cnt == 5'd1) begin
                            y_cnt <= '0;
                            state <= CP_TOP;
                        end else begin
                            y_cnt <= y_cnt - 5'd1;
                        end
                    end else begin
                        x_cnt <= x_cnt + 6'd1;
                    end
                end
                CP_TOP: begin
                    if (x_cnt == LAST_X)
                        state <= IDLE;
                    else
                        x_cnt <= x_cnt + 6'd1;
                end
                default:  state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ram_wen   = 1'b0;
        ram_ren   = 1'b0;
        ram_waddr = cell_addr;
        ram_raddr = cell_addr;
        ram_wdata = data_q;
        case (state)
            WR:       ram_wen = 1'b1;
            RD_ISSUE: ram_ren = 1'b1;
            CLR: begin
                ram_wen   = 1'b1;
                ram_waddr = clr_cnt;
            end
            CP_RD: begin
                ram_ren   = 1'b1;
                ram_raddr = src_addr;
            end
            CP_WR: begin
                ram_wen   = 1'b1;
                ram_wdata = ram_rdata;
            end
            CP_TOP: begin
                ram_wen   = 1'b1;
                ram_wdata = '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_map_ram_ctrl.sv
// Scoreboard bench for map_ram_ctrl: behavioural RAM, queued read expectations, directed op sequences.
module tb_map_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_x;
    logic [4:0]  cmd_y;
    logic [3:0]  cmd_data;
    logic        rsp_valid;
    logic [3:0]  rsp_data;
    logic        busy;
    logic        cmd_err;
    logic        ram_wen;
    logic [11:0] ram_waddr;
    logic [3:0]  ram_wdata;
    logic        ram_ren;
    logic [11:0] ram_raddr;
    logic [3:0]  ram_rdata;

    map_ram_ctrl #(.COLS(40), .ROWS(30)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .cmd_err(cmd_err),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [0:4095];
    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= mem[ram_raddr];
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  data;
        int unsigned at;
    } exp_t;
    exp_t sb[$];

    int total  = 0;
    int passed = 0;
    int wen_cnt = 0;
    int err_cnt = 0;
    logic [11:0] last_waddr = '0;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (ram_wen) begin
            wen_cnt++;
            last_waddr = ram_waddr;
        end
        if (cmd_err) err_cnt++;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", int'(rsp_data), int'(e.data));
                chk("rsp_latency", int'(cyc), int'(e.at));
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [5:0] x, input logic [4:0] y,
                        input logic [3:0] d, output int unsigned acc);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_data = d;
        n = 0;
        while (!cmd_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            $display("FAIL accept_timeout: got 0 expected 1");
            $fatal(1, "command never accepted");
        end
        acc = cyc;
        @(posedge clk);
    endtask

    task automatic rd(input logic [5:0] x, input logic [4:0] y, input logic [3:0] exp);
        int unsigned acc;
        exp_t e;
        send(2'd1, x, y, 4'd0, acc);
        e.data = exp;
        e.at   = acc + 3;
        sb.push_back(e);
    endtask

    task automatic wr(input logic [5:0] x, input logic [4:0] y, input logic [3:0] d);
        int unsigned acc;
        send(2'd0, x, y, d, acc);
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (!busy) return;
            cnt++;
        end
        chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int unsigned acc;
        int cnt, w0, e0, bad_addr, bad_rdy, idx;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0; cmd_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", int'(cmd_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_data", int'(rsp_data), 0);
        chk("reset_ram_en", int'({ram_wen, ram_ren}), 0);
        chk("reset_cmd_err", int'(cmd_err), 0);
        rst = 1'b0;

        // Single write then read at (5,3)
        wr(6'd5, 5'd3, 4'hA);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        chk("write_addr_5_3", int'(last_waddr), 125);
        rd(6'd5, 5'd3, 4'hA);
        wait_idle(cnt);
        chk("read_busy_cycles", cnt, 2);

        // Full clear with 0
        w0 = wen_cnt;
        send(2'd2, 6'd0, 5'd0, 4'h0, acc);
        cnt = 0; bad_addr = 0; bad_rdy = 0; idx = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (!busy) break;
            cnt++;
            if (!ram_wen || int'(ram_waddr) != idx) bad_addr++;
            if (cmd_ready) bad_rdy++;
            idx++;
        end
        @(negedge clk);
        chk("clear_busy_cycles", cnt, 1200);
        chk("clear_wen_count", wen_cnt - w0, 1200);
        chk("clear_addr_seq_errors", bad_addr, 0);
        chk("clear_ready_high", bad_rdy, 0);

        // Fill with 5, preload rows 28/29, collapse r=29
        send(2'd2, 6'd0, 5'd0, 4'h5, acc);
        wait_idle(cnt);
        for (int x = 0; x < 40; x++) begin
            wr(6'(x), 5'd28, 4'h3);
            wr(6'(x), 5'd29, 4'h7);
        end
        wait_idle(cnt);
        send(2'd3, 6'd0, 5'd29, 4'd0, acc);
        wait_idle(cnt);
        chk("collapse29_cycles", cnt, 2360);
        rd(6'd0,  5'd29, 4'h3);
        rd(6'd39, 5'd29, 4'h3);
        rd(6'd7,  5'd28, 4'h5);
        rd(6'd20, 5'd1,  4'h5);
        rd(6'd0,  5'd0,  4'h0);
        rd(6'd39, 5'd0,  4'h0);

        // Collapse r=0 only clears row 0
        wr(6'd3, 5'd0, 4'h9);
        send(2'd3, 6'd0, 5'd0, 4'd0, acc);
        wait_idle(cnt);
        chk("collapse0_cycles", cnt, 40);
        rd(6'd3, 5'd0, 4'h0);
        rd(6'd3, 5'd1, 4'h5);

        // Reset in the middle of a clear
        send(2'd2, 6'd0, 5'd0, 4'hF, acc);
        @(negedge clk); cmd_valid = 1'b0;
        repeat (499) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_wen", int'(ram_wen), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(cmd_ready), 1);
        rst = 1'b0;
        rd(6'd5, 5'd3, 4'hF);
        wait_idle(cnt);

        // Out-of-range column
        e0 = err_cnt; w0 = wen_cnt;
        send(2'd0, 6'd40, 5'd0, 4'hC, acc);
        repeat (3) begin @(negedge clk); cmd_valid = 1'b0; end
`ifdef MAPCTRL_BOUNDS_CHECK_EN
        chk("bounds_err_pulses", err_cnt - e0, 1);
        chk("bounds_no_wen", wen_cnt - w0, 0);
`else
        chk("unchecked_wen", wen_cnt - w0, 1);
        chk("unchecked_addr", int'(last_waddr), 40);
        chk("unchecked_no_err", err_cnt - e0, 0);
`endif

        // Back-to-back with cmd_valid held high
        w0 = wen_cnt;
        wr(6'd1, 5'd1, 4'h2);
        wr(6'd2, 5'd1, 4'h4);
        rd(6'd1, 5'd1, 4'h2);
        rd(6'd2, 5'd1, 4'h4);
        wait_idle(cnt);
        @(negedge clk);
        chk("b2b_wen_count", wen_cnt - w0, 2);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/map_ram_ctrl.md
MAP_RAM_CTRL -- requirements
Module: map_ram_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 40, meaning map width in cells.
REQ-002 SHALL have parameter ROWS, default 30, meaning map height in cells.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd_op, input, 2 bits: 0 = write cell, 1 = read cell, 2 = clear map, 3 = collapse row.
REQ-008 SHALL have ports cmd_x (input, 6 bits, column) and cmd_y (input, 5 bits, row).
REQ-009 SHALL have port cmd_data, input, 4 bits: cell value for op 0 and fill value for op 2.
REQ-010 SHALL have ports rsp_valid (output, 1 bit, one-cycle pulse) and rsp_data (output, 4 bits): read result.
REQ-011 SHALL have port busy, output, 1 bit: high while any command is executing.
REQ-012 SHALL have port cmd_err, output, 1 bit: one-cycle pulse when a command is rejected.
REQ-013 SHALL have RAM ports ram_wen (output, 1), ram_waddr (output, 12), ram_wdata (output, 4), ram_ren (output, 1), ram_raddr (output, 12) and ram_rdata (input, 4); ram_rdata is valid one cycle after ram_ren.

Function
REQ-014 SHALL compute every RAM address as y*COLS+x, 12 bits, with no division.
REQ-015 SHALL use FSM states IDLE, WR, RD_ISSUE, RD_DATA, CLR, CP_RD, CP_WR and CP_TOP.
REQ-016 SHALL assert cmd_ready only in IDLE; commands SHALL NOT be queued.
REQ-017 Op 0 SHALL go IDLE->WR and drive ram_wen for one cycle with cmd_data; accept-to-IDLE takes 1 cycle.
REQ-018 Op 1 SHALL go IDLE->RD_ISSUE (ram_ren)->RD_DATA, then pulse rsp_valid with rsp_data = ram_rdata; rsp_valid rises 2 cycles after accept.
REQ-019 Op 2 SHALL write cmd_data to addresses 0..COLS*ROWS-1 ascending, one per cycle, in CLR; it lasts exactly COLS*ROWS cycles (1200 at default).
REQ-020 Op 3 with row r SHALL copy, for y = r down to 1 and x = 0..COLS-1, cell (x,y-1) to (x,y).
  - Each cell takes 2 cycles: CP_RD issues ram_ren, CP_WR issues ram_wen.
  - CP_TOP then writes 0 to row 0 at one cell per cycle.
  - Total duration is r*COLS*2 + COLS cycles.
REQ-021 Op 3 with r = 0 SHALL only clear row 0 (COLS cycles).
REQ-022 busy SHALL be high from the cycle after accept until the FSM is back in IDLE.
REQ-023 ram_wen and ram_ren SHALL never both be high on the same address in the same cycle.
REQ-024 Outside active states, ram_wen and ram_ren SHALL be 0; address and data outputs are don't-care.
REQ-025 The x counter SHALL wrap at COLS-1 to 0, the row counter SHALL decrement, and termination SHALL be on the terminal count, never on an underflow.

Reset
REQ-026 On rst, the FSM SHALL go to IDLE and cmd_ready SHALL be 1.
REQ-027 On rst, busy, rsp_valid, cmd_err, ram_wen and ram_ren SHALL be 0, and counters and rsp_data SHALL be 0.
REQ-028 Reset during any operation SHALL abort it immediately; partial map contents are left as-is and no response is issued.

Configuration
REQ-029 With MAPCTRL_BOUNDS_CHECK_EN defined, an accepted command SHALL be rejected if cmd_x >= COLS (ops 0/1) or cmd_y >= ROWS (ops 0/1/3).
  - Rejection pulses cmd_err for one cycle, performs no RAM access and stays in IDLE.
REQ-030 Without MAPCTRL_BOUNDS_CHECK_EN, cmd_err SHALL be tied 0 and out-of-range coordinates SHALL be used unchecked.

Verification
REQ-031 Write op 0 at (5,3) with data 0xA, then read op 1 at (5,3) -> ram_waddr = 125; rsp_valid 2 cycles after accept with rsp_data = 0xA.
REQ-032 Clear op 2 with data 0x0 -> exactly 1200 ram_wen cycles on addresses 0..1199; busy for 1200 cycles; cmd_ready low throughout.
REQ-033 Preload row 28 = 0x3 and row 29 = 0x7, then collapse op 3 with r = 29 -> row 29 = 0x3 and row 0 = 0; duration 29*80+40 = 2360 cycles.
REQ-034 Assert rst mid-clear at cycle 500 -> next cycle ram_wen = 0, busy = 0, cmd_ready = 1; a subsequent op 1 works normally.
REQ-035 With MAPCTRL_BOUNDS_CHECK_EN, op 0 at (40,0) -> cmd_err pulse and no ram_wen; without the macro, ram_waddr = 40.
REQ-036 Hold cmd_valid high with back-to-back ops -> each is accepted only in an IDLE cycle; no command is lost or duplicated.
